// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton pulse generator: the debounce FSM
// state encoding and the default timing constants used by btn_pulse_gen.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_CNT_W           = 20;
    localparam int DEF_REPEAT_DELAY    = 50_000_000;
    localparam int DEF_REPEAT_PERIOD   = 10_000_000;

endpackage

// File: rtl/btn_pulse_gen_if.sv
// Button bus: raw pushbutton level in, strobe and debounced level out.
// The slave modport is the generator side, the master modport is the
// side that owns the button and consumes the strobe.
interface btn_pulse_gen_if;

    logic btn_in;
    logic pulse_o;
    logic level_o;

    modport master (
        output btn_in,
        input  pulse_o,
        input  level_o
    );

    modport slave (
        input  btn_in,
        output pulse_o,
        output level_o
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_pulse_gen.sv
// Pushbutton debouncer and single-cycle pulse generator.
// The raw button is synchronized, qualified by a four-state debounce FSM,
// and each qualified press produces one registered strobe on pulse_o while
// level_o carries the debounced level.
// Optional feature: define BTN_AUTOREPEAT_EN to add hold-to-repeat strobes
// (first after REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles).
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    btn_pulse_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Reject parameter sets the counters cannot represent at elaboration.
    if ((DEBOUNCE_CYCLES < 2) ||
        (longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1)) ||
        (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_param_check
        $error("btn_pulse_gen: timing parameter out of range");
    end

    logic             s;
    btn_state_e       state;
    btn_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             pulse_q;
    logic             pulse_next;
    logic             level_q;
    logic             level_next;
    logic             repeat_fire;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (s)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // State, debounce counter and both outputs are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pulse_q <= pulse_next;
            level_q <= level_next;
        end
    end

    // Debounce FSM: a level change must hold stable for DEBOUNCE_CYCLES samples.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_next = PRESSED;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = PRESSED;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Strobe on qualification (or repeat), never twice in a row; level follows the held states.
    always_comb begin
        pulse_next = ((state == PRESS_WAIT) && (state_next == PRESSED)) || repeat_fire;
        if (pulse_q) begin
            pulse_next = 1'b0;
        end
        level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

`ifdef BTN_AUTOREPEAT_EN
    // The repeat counter is sized from the repeat timings, not from CNT_W,
    // because the hold delays are typically far longer than the debounce window.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic             rpt_hold;

    assign rpt_hold    = (state == PRESSED) && (state_next == PRESSED);
    assign repeat_fire = rpt_hold && (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST));

    // Count held cycles in PRESSED; any exit or fresh entry restarts the initial delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!rpt_hold) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (repeat_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign bus.pulse_o = pulse_q;
    assign bus.level_o = level_q;

endmodule
